// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM stage with req/ack data-memory port, bus timeout, stall, byte lanes and load extension
module mem_stage_hs #(
  parameter int XLEN = 64,
  parameter int CST_W = 19,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MEM_V,
  input  logic [CST_W-1:0]    MEM_Cst,
  input  logic [XLEN-1:0]     MEM_RES,
  input  logic [XLEN-1:0]     MEM_Address,
  input  logic [XLEN-1:0]     MEM_NPC,
  input  logic [XLEN-1:0]     MEM_Target_Address,
  input  logic                MEM_PC_MUX,
  input  logic [31:0]         MEM_IR,
  output logic                DMEM_REQ,
  output logic                DMEM_WE,
  output logic [XLEN-1:0]     DMEM_ADDR,
  output logic [XLEN-1:0]     DMEM_WDATA,
  output logic [XLEN/8-1:0]   DMEM_BE,
  input  logic                DMEM_ACK,
  input  logic [XLEN-1:0]     DMEM_RDATA,
  output logic                MEM_STALL,
  output logic                V_MEM_FE_BR_STALL,
  output logic [4:0]          MEM_DR,
  output logic                WB_V,
  output logic                WB_PC_MUX,
  output logic [CST_W-1:0]    WB_Cst,
  output logic [XLEN-1:0]     WB_RES,
  output logic [XLEN-1:0]     WB_NPC,
  output logic [XLEN-1:0]     WB_Target_Address,
  output logic [31:0]         WB_IR,
  output logic [1:0]          WB_EXC
);
  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int LW = $clog2(XLEN);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cur;
  logic [2:0] sz;
  logic [1:0] lg;
  logic [OW:0] nb;
  logic [OW-1:0] off;
  logic [OW+3:0] nbits;
  logic [LW-1:0] sbit;
  logic [XLEN-1:0] sh, dmask, ld_res;
  logic [BW-1:0] bmask;
  logic rw, ld, access, mis, sx, abort;
  always_comb begin
    rw = MEM_Cst[5];
    ld = MEM_Cst[1] & ~rw;
    sz = MEM_Cst[4:2];
    lg = (sz[1:0] > 2'(OW)) ? 2'(OW) : sz[1:0];
    sx = ~(sz[2] & (sz != 3'b111));
    nb = '0;
    nb[lg] = 1'b1;
    off = MEM_Address[OW-1:0];
    access = MEM_V & (rw | MEM_Cst[1]);
    mis = access & (|(off & (OW'(nb) - 1'b1)));
    cur = (state == S_WAIT) ? cnt : '0;
    DMEM_REQ = ~RESET & ((state == S_WAIT) | (access & ~mis));
    abort = DMEM_REQ & ~DMEM_ACK & (32'(cur) == TIMEOUT - 1);
    MEM_STALL = DMEM_REQ & ~DMEM_ACK & ~abort;
    DMEM_WE = DMEM_REQ & rw;
    DMEM_ADDR = MEM_Address & ~XLEN'(BW - 1);
    bmask = ~({BW{1'b1}} << nb);
    DMEM_BE = DMEM_REQ ? (bmask << off) : '0;
    DMEM_WDATA = MEM_RES << {off, 3'b000};
    nbits = {nb, 3'b000};
    sbit = LW'(nbits - 1'b1);
    sh = DMEM_RDATA >> {off, 3'b000};
    dmask = ~({XLEN{1'b1}} << nbits);
    ld_res = (sh & dmask) | ((sx & sh[sbit]) ? ~dmask : '0);
    V_MEM_FE_BR_STALL = MEM_V & ((MEM_IR[6:2] == 5'b11000) | (MEM_IR[6:2] == 5'b11001) | (MEM_IR[6:2] == 5'b11011));
    MEM_DR = MEM_IR[11:7];
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == S_IDLE) begin
      if (MEM_STALL) begin
        state_n = S_WAIT;
        cnt_n = CW'(1);
      end
    end else if (DMEM_ACK | abort) begin
      state_n = S_IDLE;
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt <= '0;
      WB_V <= 1'b0;
      WB_PC_MUX <= 1'b0;
      WB_Cst <= '0;
      WB_RES <= '0;
      WB_NPC <= '0;
      WB_Target_Address <= '0;
      WB_IR <= '0;
      WB_EXC <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      WB_V <= MEM_V & ~MEM_STALL;
      if (!MEM_STALL) begin
        WB_PC_MUX <= MEM_PC_MUX;
        WB_Cst <= MEM_Cst;
        WB_RES <= (ld & DMEM_REQ & DMEM_ACK) ? ld_res : MEM_RES;
        WB_NPC <= MEM_NPC;
        WB_Target_Address <= MEM_Target_Address;
        WB_IR <= MEM_IR;
        WB_EXC <= mis ? 2'b01 : abort ? 2'b10 : 2'b00;
      end
    end
  end
endmodule

// File: doc/mem_stage_hs.md
# mem_stage_hs

Parametrised MEM pipeline stage for the RISC-V core that replaces the fixed single-cycle data-memory access with a request/acknowledge data-memory port. It adds a bus timeout and a pipeline stall output, and supports sub-word loads and stores with byte lanes and sign or zero extension. It also flags misaligned accesses. It sits between EX and WB, registers the WB_* bundle, and keeps the existing branch-stall and destination-register outputs.

## Interface
- XLEN, 64: data/address width; power of two, 32 or 64
- CST_W, 19: control-store word width
- TIMEOUT, 16: max cycles DMEM_REQ is held for one access before abort; ≥1
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- MEM_V  in  1  valid instruction in MEM
- MEM_Cst  in  CST_W  control: [5] R_W (1=store), [4:2] Size, [1] RES_Mux (1=load)
- MEM_RES, MEM_Address, MEM_NPC, MEM_Target_Address  in  XLEN  ALU result/store data, effective address, next PC, branch target
- MEM_PC_MUX  in  1  PC select; MEM_IR  in  32  instruction
- DMEM_REQ  out  1  access request; DMEM_WE  out  1  1=write
- DMEM_ADDR  out  XLEN  = MEM_Address with low log2(XLEN/8) bits cleared
- DMEM_WDATA  out  XLEN  store data shifted to byte lanes; DMEM_BE  out  XLEN/8  byte enables
- DMEM_ACK  in  1  access complete this cycle; DMEM_RDATA  in  XLEN  read data, valid with ACK
- MEM_STALL  out  1  hold EX/MEM inputs stable this cycle
- V_MEM_FE_BR_STALL  out  1  MEM_V and IR[6:2] ∈ {11000, 11001, 11011}
- MEM_DR  out  5  MEM_IR[11:7]
- WB_V, WB_PC_MUX  out  1; WB_Cst  out  CST_W; WB_RES, WB_NPC, WB_Target_Address  out  XLEN; WB_IR  out  32
- WB_EXC  out  2  00 none, 01 misaligned, 10 bus timeout

## Operation
- Access = MEM_V & (R_W | RES_Mux). Size: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU; other codes are treated as D.
- Misaligned: the address is not a multiple of the access size. No request is issued. Retires next edge with WB_V=1, WB_EXC=01, WB_RES=MEM_RES, no stall.
- Byte offset off = MEM_Address[log2(XLEN/8)-1:0]. Store: WDATA = MEM_RES << 8·off, BE = size mask << off. Load: BE = same mask, WE=0.
- Load result: RDATA >> 8·off, truncated to size, sign-extended (B/H/W) or zero-extended (BU/HU/WU).
- FSM IDLE/WAIT; cnt counts request cycles.
  - IDLE: aligned access → DMEM_REQ=1. If ACK is seen: retire at the edge, stay IDLE. Otherwise go to WAIT with cnt=1.
  - WAIT: DMEM_REQ=1 with the same addr/WE/BE/WDATA.
    - ACK: retire, go to IDLE.
    - Else if cnt==TIMEOUT-1: retire with WB_EXC=10, go to IDLE.
    - Else cnt+1.
- MEM_STALL = DMEM_REQ & ~DMEM_ACK & ~(timeout abort this cycle). Upstream holds all MEM_* stable while MEM_STALL=1.
- On every edge with MEM_STALL=1, WB_V<=0 (bubble). Other WB_* fields may update freely.
- Retire (non-stall edge): WB_V<=MEM_V. Cst/IR/NPC/PC_MUX/Target are copied. WB_RES<=load result if a load completes with ACK, else MEM_RES. WB_EXC<=the code, or 00.
- Non-access or MEM_V=0 instructions pass through in 1 cycle. No request is issued.
- DMEM_ACK while DMEM_REQ=0 is ignored.

## Timing
- Reset, at the edge with RESET=1:
  - WB_V, WB_PC_MUX, WB_EXC are cleared to 0. All WB_* buses are cleared to 0. FSM goes to IDLE, cnt=0.
  - DMEM_REQ is forced 0 combinationally while RESET=1. An in-flight access is dropped without retiring.
- Latency: zero-wait access and pass-through take 1 cycle to WB. An access with ACK after k wait cycles takes k+1 cycles, with MEM_STALL high for k cycles.
- Timeout: REQ is held for exactly TIMEOUT cycles. For TIMEOUT=1 an un-ACKed IDLE request aborts at the first edge.
- ACK on the final timeout cycle counts as success, not timeout.
- Back-to-back accesses: a new request may be issued the cycle after retire. No dead cycle.
- V_MEM_FE_BR_STALL and MEM_DR are combinational from MEM_V/MEM_IR and are unaffected by FSM state.

## Test plan
- Zero-wait LB, XLEN=64, addr 0x1003, RDATA=0x0000_0000_8000_0000:
  - BE=0x08, MEM_STALL never high.
  - Next edge: WB_V=1, WB_RES=0xFFFF_FFFF_FFFF_FF80.
  - Repeat as LBU → WB_RES=0x80.
- SH at addr 0x6, MEM_RES=0xBEEF, ACK after 3 wait cycles:
  - BE=0xC0, WDATA[63:48]=0xBEEF, WE=1.
  - MEM_STALL high 3 cycles, WB_V=0 during those cycles.
  - Then WB_V=1, WB_RES=0xBEEF, WB_EXC=00.
- LW at addr 0x2:
  - DMEM_REQ stays 0, no stall.
  - Next edge: WB_V=1, WB_EXC=01.
- TIMEOUT=4, LD with ACK held 0:
  - REQ high exactly 4 cycles, then drops.
  - WB_V=1, WB_EXC=10.
  - Repeat with ACK in cycle 4 → success, WB_EXC=00.
- RESET asserted in WAIT cycle 2:
  - REQ=0 that cycle; next cycle state IDLE, WB_V=0, WB_EXC=0.
  - A subsequent SD completes normally.
- JAL (IR[6:2]=11011) with MEM_V=1:
  - V_MEM_FE_BR_STALL=1, no request.
  - Next edge: WB_RES=MEM_RES, WB_NPC/WB_Target_Address copied.
  - MEM_DR=IR[11:7].
